// File: rtl/ioctl_loader.sv
// ioctl_loader: ioctl download -> 16-bit memory writes via a write FIFO.
// Ports: ioctl_* (source, wait), mem_* (req/ack sink), busy/done/err.
module ioctl_loader #(
  parameter int IW = 16,
  parameter int NREG = 2,
  parameter logic [NREG*6-1:0] REGION_INDEX = {6'd1, 6'd0},
  parameter logic [NREG*25-1:0] REGION_BASE = {25'h0800000, 25'h0},
  parameter logic [NREG-1:0] REGION_SWAP = 2'b01,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          ioctl_download,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_wr,
  input  logic [24:0]   ioctl_addr,
  input  logic [IW-1:0] ioctl_dout,
  output logic          ioctl_wait,
  output logic          mem_req,
  output logic [24:0]   mem_addr,
  output logic [15:0]   mem_din,
  output logic [1:0]    mem_be,
  input  logic          mem_ack,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_FLUSH, S_DRAIN, S_DONE
  } state_t;

  typedef struct packed {
    logic [24:0] addr;
    logic [15:0] data;
    logic [1:0]  be;
  } ent_t;

  localparam int AW = $clog2(FIFO_DEPTH);

  state_t state, state_n;
  ent_t fifo [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt, cnt_n;

  logic held_v, held_v_n;
  logic [24:0] held_a, held_a_n;
  logic [7:0] held_d, held_d_n;

  logic hit, hit_swap;
  logic [24:0] hit_base, baddr;
  logic wr_ok, acc, pop;
  logic p0_v, p1_v, ok0, ok1;
  ent_t p0, p1, held_e, odd_e;
  logic [15:0] dw;
  logic unused_idx;

  assign unused_idx = ^ioctl_index[7:6];
  assign dw = 16'(ioctl_dout);

  // Descending scan so the lowest-numbered region wins.
  always_comb begin
    hit = 1'b0;
    hit_swap = 1'b0;
    hit_base = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (ioctl_index[5:0] == REGION_INDEX[i*6 +: 6]) begin
        hit = 1'b1;
        hit_swap = REGION_SWAP[i];
        hit_base = REGION_BASE[i*25 +: 25];
      end
    end
  end

  assign baddr = hit_base + ioctl_addr;
  assign wr_ok = ioctl_wr &
    ((state == S_LOAD) |
     ((state == S_IDLE) & ioctl_download));
  assign acc = wr_ok & hit;
  assign pop = mem_req & mem_ack;

  assign held_e = {held_a, 8'h00, held_d, 2'b01};
  assign odd_e = {baddr[24:1], 1'b0,
                  dw[7:0], 8'h00, 2'b10};

  // Up to two pushes per cycle: an odd byte that breaks
  // a held even byte emits the orphan first, then itself.
  always_comb begin
    p0_v = 1'b0;
    p1_v = 1'b0;
    p0 = '0;
    p1 = '0;
    held_v_n = held_v;
    held_a_n = held_a;
    held_d_n = held_d;
    if (state == S_FLUSH) begin
      if (held_v) begin
        p0_v = 1'b1;
        p0 = held_e;
        held_v_n = 1'b0;
      end
    end else if (acc) begin
      if (IW == 16) begin
        p0_v = 1'b1;
        p0.addr = {baddr[24:1], 1'b0};
        p0.data = hit_swap ? {dw[7:0], dw[15:8]} : dw;
        p0.be = 2'b11;
      end else if (!baddr[0]) begin
        p0_v = held_v;
        p0 = held_e;
        held_v_n = 1'b1;
        held_a_n = baddr;
        held_d_n = dw[7:0];
      end else if (held_v &&
                   baddr == held_a + 25'd1) begin
        p0_v = 1'b1;
        p0 = {held_a, dw[7:0], held_d, 2'b11};
        held_v_n = 1'b0;
      end else begin
        held_v_n = 1'b0;
        p0_v = 1'b1;
        if (held_v) begin
          p0 = held_e;
          p1_v = 1'b1;
          p1 = odd_e;
        end else begin
          p0 = odd_e;
        end
      end
    end
  end

  // A pop frees its slot for a push in the same cycle.
  always_comb begin
    ok0 = p0_v &&
      (int'(cnt) < FIFO_DEPTH + int'(pop));
    ok1 = p1_v && ok0 &&
      (int'(cnt) + 1 < FIFO_DEPTH + int'(pop));
    cnt_n = cnt + (AW+1)'(ok0) + (AW+1)'(ok1)
          - (AW+1)'(pop);
  end

  always_ff @(posedge clk_sys) begin
    if (ok0) fifo[wp] <= p0;
    if (ok1) fifo[wp + AW'(1)] <= p1;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (ioctl_download) state_n = S_LOAD;
      S_LOAD:  if (!ioctl_download) state_n = S_FLUSH;
      S_FLUSH: state_n = S_DRAIN;
      S_DRAIN: if (cnt == '0 && !mem_req)
                 state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      held_v <= 1'b0;
      held_a <= '0;
      held_d <= '0;
      ioctl_wait <= 1'b0;
      mem_req <= 1'b0;
      mem_addr <= '0;
      mem_din <= '0;
      mem_be <= '0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      wp <= wp + AW'(ok0) + AW'(ok1);
      rp <= rp + AW'(pop);
      cnt <= cnt_n;
      held_v <= held_v_n;
      held_a <= held_a_n;
      held_d <= held_d_n;
      ioctl_wait <= int'(cnt_n) >= FIFO_DEPTH - 1;
      if (wr_ok && !hit)
        err <= 1'b1;
      else if (state == S_IDLE && ioctl_download)
        err <= 1'b0;
      // Head stays in the FIFO until acked; the next
      // entry is loaded one cycle after the pop.
      if (pop) begin
        mem_req <= 1'b0;
      end else if (!mem_req && cnt != '0) begin
        mem_req <= 1'b1;
        mem_addr <= fifo[rp].addr;
        mem_din <= fifo[rp].data;
        mem_be <= fifo[rp].be;
      end
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

endmodule
